// File: rtl/mips_dmem_pipe.sv
// MIPS data memory for the MEM stage: byte/half/word access, load extension, fixed read latency,
// zero-fill clear sequencer. Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors.
module mips_dmem_pipe #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned LAST  = RD_LAT - 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [31:0] mem [DEPTH];

  // Clear sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (CLR) begin
      state_d = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      cnt_d   = '0;
    end else if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign req_ready = (state_q == S_RUN);

  // Request decode
  logic             accept;
  logic             is_word, is_half, is_byte;
  logic [1:0]       off;
  logic             do_access;
  logic             trap_hit;
  logic [IDX_W-1:0] idx;

  assign accept  = req_valid & req_ready & ~CLR;
  assign is_half = (req_size == 2'b01);
  assign is_byte = (req_size == 2'b10);
  assign is_word = ~is_half & ~is_byte;
  assign idx     = req_addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign  = (is_half & req_addr[0]) | (is_word & (|req_addr[1:0]));
  assign off       = req_addr[1:0];
  assign do_access = ~misalign;
  assign trap_hit  = accept & misalign;
`else
  // Misaligned addresses are silently rounded down to the access size.
  assign off       = is_word ? 2'b00 : (is_half ? {req_addr[1], 1'b0} : req_addr[1:0]);
  assign do_access = 1'b1;
  assign trap_hit  = 1'b0;
`endif

  // Store lane steering
  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    st_be   = 4'b1111;
    st_data = req_wdata;
    if (is_byte) begin
      st_be   = 4'b0001 << off;
      st_data = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      st_be   = off[1] ? 4'b1100 : 4'b0011;
      st_data = {2{req_wdata[15:0]}};
    end
  end

  // Single write port shared by the clear sequencer and stores
  logic [3:0]       mem_be;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;

  always_comb begin
    mem_be    = 4'b0000;
    mem_widx  = idx;
    mem_wdata = st_data;
    if (state_q == S_CLEAR && !CLR) begin
      mem_be    = 4'b1111;
      mem_widx  = cnt_q;
      mem_wdata = '0;
    end else if (accept && req_we && do_access) begin
      mem_be = st_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_be[k]) mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  // Load response pipeline, RD_LAT stages deep
  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] perr_q;
  logic [RD_LAT-1:0] puns_q;
  logic [1:0]        psize_q [RD_LAT];
  logic [1:0]        poff_q  [RD_LAT];
  logic [31:0]       pword_q [RD_LAT];
  logic              v0;

  assign v0 = (accept & ~req_we) | trap_hit;

  always_ff @(posedge clk) begin
    if (CLR) begin
      pv_q   <= '0;
      perr_q <= '0;
    end else begin
      pv_q[0]   <= v0;
      perr_q[0] <= trap_hit;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        perr_q[i] <= perr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pword_q[0] <= mem[idx];
    psize_q[0] <= req_size;
    poff_q[0]  <= off;
    puns_q[0]  <= req_unsigned;
    for (int i = 1; i < RD_LAT; i++) begin
      pword_q[i] <= pword_q[i-1];
      psize_q[i] <= psize_q[i-1];
      poff_q[i]  <= poff_q[i-1];
      puns_q[i]  <= puns_q[i-1];
    end
  end

  // Lane select and extension on the final stage
  logic [31:0] out_word;
  logic [1:0]  out_off;
  logic [7:0]  out_byte;
  logic [15:0] out_half;

  assign out_word = pword_q[LAST];
  assign out_off  = poff_q[LAST];
  assign out_half = out_off[1] ? out_word[31:16] : out_word[15:0];

  always_comb begin
    case (out_off)
      2'd0:    out_byte = out_word[7:0];
      2'd1:    out_byte = out_word[15:8];
      2'd2:    out_byte = out_word[23:16];
      default: out_byte = out_word[31:24];
    endcase
  end

  assign rsp_valid = pv_q[LAST];
  assign rsp_err   = perr_q[LAST];

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !rsp_err) begin
      case (psize_q[LAST])
        2'b01:   rsp_rdata = puns_q[LAST] ? {16'h0000, out_half}
                                          : {{16{out_half[15]}}, out_half};
        2'b10:   rsp_rdata = puns_q[LAST] ? {24'h000000, out_byte}
                                          : {{24{out_byte[7]}}, out_byte};
        default: rsp_rdata = out_word;
      endcase
    end
  end

endmodule
